// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding/redirect controller:
// forward selects, exception constants and redirect FSM states.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_E    = 2'b10;
    // Decode-stage selects use 01 for the M-stage result.
    localparam logic [1:0] FWD_D_M  = 2'b01;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000E;

    typedef enum logic {
        StIdle,
        StRedir
    } redir_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Two-source priority comparator: picks the higher-priority enabled destination
// matching a source index; index 0 never forwards.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter logic [1:0]  SEL_HI = FWD_M,
    parameter logic [1:0]  SEL_LO = FWD_W
) (
    input  logic [AW-1:0] idx,
    input  logic [AW-1:0] dest_hi,
    input  logic          en_hi,
    input  logic [AW-1:0] dest_lo,
    input  logic          en_lo,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_NONE;
        if (idx != '0) begin
            if (en_hi && (dest_hi == idx)) begin
                sel = SEL_HI;
            end else if (en_lo && (dest_lo == idx)) begin
                sel = SEL_LO;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and exception-redirect controller for the 5-stage pipeline,
// with a saturating count of fetch-stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned PC_W       = 32,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              balD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              mdu_busyE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writecp0M,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              hilowriteM,
    input  logic              cp0writeM,
    input  logic              dstallM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic [REG_AW-1:0] writecp0W,
    input  logic              regwriteW,
    input  logic              hilowriteW,
    input  logic              cp0writeW,
    input  logic [31:0]       excepttypeW,
    input  logic [PC_W-1:0]   cp0_epcW,
    input  logic              ifetch_ready,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    output logic [1:0]        forwardjrD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardhE,
    output logic [1:0]        forwardcp0E,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   newpc,
    output logic [CNT_W-1:0]  stall_cycles
);

    redir_state_e      state_q, state_d;
    logic [PC_W-1:0]   newpc_q, newpc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              exc_take, lwstall, brstall;

    hazard_ctrl_fwd_sel #(.AW(REG_AW), .SEL_HI(FWD_M), .SEL_LO(FWD_W)) u_fwd_a_e (
        .idx(rsE), .dest_hi(writeregM), .en_hi(regwriteM),
        .dest_lo(writeregW), .en_lo(regwriteW), .sel(forwardaE)
    );
    hazard_ctrl_fwd_sel #(.AW(REG_AW), .SEL_HI(FWD_M), .SEL_LO(FWD_W)) u_fwd_b_e (
        .idx(rtE), .dest_hi(writeregM), .en_hi(regwriteM),
        .dest_lo(writeregW), .en_lo(regwriteW), .sel(forwardbE)
    );
    hazard_ctrl_fwd_sel #(.AW(REG_AW), .SEL_HI(FWD_M), .SEL_LO(FWD_W)) u_fwd_cp0_e (
        .idx(rdE), .dest_hi(writecp0M), .en_hi(cp0writeM),
        .dest_lo(writecp0W), .en_lo(cp0writeW), .sel(forwardcp0E)
    );
    hazard_ctrl_fwd_sel #(.AW(REG_AW), .SEL_HI(FWD_E), .SEL_LO(FWD_D_M)) u_fwd_jr_d (
        .idx(rsD), .dest_hi(writeregE), .en_hi(regwriteE),
        .dest_lo(writeregM), .en_lo(regwriteM), .sel(forwardjrD)
    );

    assign forwardaD = ((rsD != '0) && regwriteM && (writeregM == rsD)) ? FWD_D_M : FWD_NONE;
    assign forwardbD = ((rtD != '0) && regwriteM && (writeregM == rtD)) ? FWD_D_M : FWD_NONE;
    assign forwardhE = hilowriteM ? FWD_M : (hilowriteW ? FWD_W : FWD_NONE);

    assign exc_take = (state_q == StIdle) && (excepttypeW != '0);
    assign lwstall  = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    assign brstall  = (branchD || jrD) &&
                      ((regwriteE && (writeregE != '0) &&
                        ((writeregE == rsD) || (writeregE == rtD))) ||
                       (memtoregM && (writeregM != '0) &&
                        ((writeregM == rsD) || (writeregM == rtD))));

    always_comb begin
        state_d = state_q;
        newpc_d = newpc_q;
        {stallF, stallD, stallE, stallM, stallW} = '0;
        {flushF, flushD, flushE, flushM, flushW} = '0;

        if (exc_take) begin
            {flushF, flushD, flushE, flushM, flushW} = '1;
        end else if (dstallM) begin
            {stallF, stallD, stallE, stallM} = '1;
            flushW = 1'b1;
        end else if (mdu_busyE) begin
            {stallF, stallD, stallE} = '1;
            flushM = 1'b1;
        end else if (lwstall || brstall) begin
            {stallF, stallD} = '1;
            // Keep the branch-and-link in E so its link write survives.
            flushE = ~balD;
        end

        unique case (state_q)
            StIdle: begin
                if (exc_take) begin
                    state_d = StRedir;
                    newpc_d = (excepttypeW == ERET_CODE) ? cp0_epcW : PC_W'(EXC_VECTOR);
                end
            end
            StRedir: begin
                flushD = 1'b1;
                stallF = 1'b0;
                if (ifetch_ready) state_d = StIdle;
            end
        endcase

        if (!resetn) begin
            {stallF, stallD, stallE, stallM, stallW} = '0;
            {flushF, flushD, flushE, flushM, flushW} = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            newpc_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            newpc_q <= newpc_d;
            if (stallF && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_redirect  = (state_q == StRedir);
    assign newpc        = newpc_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized cycles
// checked against a behavioural model of the stall/forward/redirect rules.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX = 15;
    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam logic [31:0] ERET = 32'h0000000E;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [4:0]  rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, writecp0M, writeregW, writecp0W;
    logic        branchD, jrD, balD, regwriteE, memtoregE, mdu_busyE;
    logic        regwriteM, memtoregM, hilowriteM, cp0writeM, dstallM;
    logic        regwriteW, hilowriteW, cp0writeW, ifetch_ready;
    logic [31:0] excepttypeW, cp0_epcW;

    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic [1:0]  forwardaD, forwardbD, forwardjrD, forwardaE, forwardbE, forwardhE, forwardcp0E;
    logic        pc_redirect;
    logic [31:0] newpc;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad = 0;

    bit          m_redir;
    logic [31:0] m_newpc;
    int          m_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .PC_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD), .balD(balD),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .mdu_busyE(mdu_busyE),
        .writeregM(writeregM), .writecp0M(writecp0M), .regwriteM(regwriteM),
        .memtoregM(memtoregM), .hilowriteM(hilowriteM), .cp0writeM(cp0writeM),
        .dstallM(dstallM), .writeregW(writeregW), .writecp0W(writecp0W),
        .regwriteW(regwriteW), .hilowriteW(hilowriteW), .cp0writeW(cp0writeW),
        .excepttypeW(excepttypeW), .cp0_epcW(cp0_epcW), .ifetch_ready(ifetch_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardjrD(forwardjrD),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardhE(forwardhE),
        .forwardcp0E(forwardcp0E), .pc_redirect(pc_redirect), .newpc(newpc),
        .stall_cycles(stall_cycles)
    );

    function automatic logic [9:0] ctrl_obs();
        return {stallF, stallD, stallE, stallM, stallW, flushF, flushD, flushE, flushM, flushW};
    endfunction

    function automatic logic [60:0] all_obs();
        return {ctrl_obs(), forwardaD, forwardbD, forwardjrD, forwardaE, forwardbE, forwardhE,
                forwardcp0E, pc_redirect, newpc, stall_cycles};
    endfunction

    // Reference: a source reads the youngest enabled writer of the same nonzero index.
    function automatic logic [1:0] fwd_ref(input logic [4:0] idx,
                                           input logic [4:0] d_young, input logic e_young,
                                           input logic [4:0] d_old, input logic e_old,
                                           input logic [1:0] code_young, input logic [1:0] code_old);
        if (idx == 5'd0) return 2'b00;
        if (e_young && d_young == idx) return code_young;
        if (e_old && d_old == idx) return code_old;
        return 2'b00;
    endfunction

    function automatic logic [9:0] ctrl_ref();
        logic [4:0] s;
        logic [4:0] f;
        bit lw;
        bit br;
        s = '0;
        f = '0;
        lw = memtoregE && rtE != 0 && (rsD == rtE || rtD == rtE);
        br = (branchD || jrD) &&
             ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
              (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        if (!resetn) return '0;
        if (!m_redir && excepttypeW != 0) f = 5'b11111;
        else if (dstallM) begin s = 5'b11110; f = 5'b00001; end
        else if (mdu_busyE) begin s = 5'b11100; f = 5'b00010; end
        else if (lw || br) begin s = 5'b11000; f = balD ? 5'b00000 : 5'b00100; end
        if (m_redir) begin f[3] = 1'b1; s[4] = 1'b0; end
        return {s, f};
    endfunction

    function automatic logic [60:0] all_ref();
        logic [1:0] ad, bd, hE;
        ad = (rsD != 0 && regwriteM && writeregM == rsD) ? 2'b01 : 2'b00;
        bd = (rtD != 0 && regwriteM && writeregM == rtD) ? 2'b01 : 2'b00;
        hE = hilowriteM ? 2'b10 : (hilowriteW ? 2'b01 : 2'b00);
        return {ctrl_ref(), ad, bd,
                fwd_ref(rsD, writeregE, regwriteE, writeregM, regwriteM, 2'b10, 2'b01),
                fwd_ref(rsE, writeregM, regwriteM, writeregW, regwriteW, 2'b10, 2'b01),
                fwd_ref(rtE, writeregM, regwriteM, writeregW, regwriteW, 2'b10, 2'b01),
                hE,
                fwd_ref(rdE, writecp0M, cp0writeM, writecp0W, cp0writeW, 2'b10, 2'b01),
                m_redir, m_newpc, CNT_W'(m_cnt)};
    endfunction

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, writecp0M, writeregW, writecp0W} = '0;
        {branchD, jrD, balD, regwriteE, memtoregE, mdu_busyE} = '0;
        {regwriteM, memtoregM, hilowriteM, cp0writeM, dstallM} = '0;
        {regwriteW, hilowriteW, cp0writeW, ifetch_ready} = '0;
        excepttypeW = '0;
        cp0_epcW = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        m_redir = 1'b0;
        m_newpc = '0;
        m_cnt = 0;
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1;
        resetn = 1'b0;
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8; dstallM = 1'b1; mdu_busyE = 1'b1;
        #1;
        total++;
        if (ctrl_obs() !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", ctrl_obs(), 10'b0);
        end
        tick();
        total++;
        if ({pc_redirect, newpc, stall_cycles} !== 37'b0) begin
            bad++;
            $display("FAIL reset_regs got=%b/%h/%0d want=0/0/0", pc_redirect, newpc, stall_cycles);
        end
        resetn = 1'b1;
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        #1;
        total++;
        if (ctrl_obs() !== 10'b11000_00100) begin
            bad++;
            $display("FAIL load_use_ctrl got=%b want=%b", ctrl_obs(), 10'b11000_00100);
        end
        total++;
        if ({forwardaD, forwardbD, forwardaE, forwardbE, stall_cycles} !== 12'b0) begin
            bad++;
            $display("FAIL load_use_fwd got=%b%b%b%b cnt=%0d want=0 cnt=0",
                     forwardaD, forwardbD, forwardaE, forwardbE, stall_cycles);
        end
        tick();
        total++;
        if (stall_cycles !== 4'd1) begin
            bad++;
            $display("FAIL load_use_cnt got=%0d want=1", stall_cycles);
        end
    endtask

    task automatic test_bal();
        do_reset();
        branchD = 1'b1; balD = 1'b1; regwriteE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
        #1;
        total++;
        if (ctrl_obs() !== 10'b11000_00000) begin
            bad++;
            $display("FAIL bal_brstall got=%b want=%b", ctrl_obs(), 10'b11000_00000);
        end
        balD = 1'b0;
        #1;
        total++;
        if (ctrl_obs() !== 10'b11000_00100) begin
            bad++;
            $display("FAIL brstall got=%b want=%b", ctrl_obs(), 10'b11000_00100);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
        #1;
        total++;
        if (forwardaE !== 2'b10) begin
            bad++;
            $display("FAIL fwd_m_over_w got=%b want=10", forwardaE);
        end
        rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        #1;
        total++;
        if (forwardaE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_zero got=%b want=00", forwardaE);
        end
        clear_inputs();
        rdE = 5'd12; writecp0M = 5'd12; cp0writeM = 1'b1;
        #1;
        total++;
        if (forwardcp0E !== 2'b10) begin
            bad++;
            $display("FAIL fwd_cp0_m got=%b want=10", forwardcp0E);
        end
        cp0writeM = 1'b0; writecp0M = 5'd0; writeregM = 5'd12; regwriteM = 1'b1;
        writecp0W = 5'd12; cp0writeW = 1'b1;
        #1;
        total++;
        if (forwardcp0E !== 2'b01) begin
            bad++;
            $display("FAIL fwd_cp0_w got=%b want=01", forwardcp0E);
        end
        clear_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        excepttypeW = 32'd1; dstallM = 1'b1;
        #1;
        total++;
        if ({ctrl_obs(), pc_redirect} !== 11'b00000_11111_0) begin
            bad++;
            $display("FAIL exc_flush got=%b/%b want=0000011111/0", ctrl_obs(), pc_redirect);
        end
        tick();
        excepttypeW = '0; dstallM = 1'b0;
        #1;
        total++;
        if ({pc_redirect, newpc, stallF, flushD} !== {1'b1, EXC_VEC, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL exc_redirect got=%b/%h sF=%b fD=%b want=1/%h sF=0 fD=1",
                     pc_redirect, newpc, stallF, flushD, EXC_VEC);
        end
        // An exception presented while redirecting must be ignored.
        excepttypeW = ERET; cp0_epcW = 32'h0000_1234;
        #1;
        total++;
        if (ctrl_obs() !== 10'b00000_01000) begin
            bad++;
            $display("FAIL exc_in_redir got=%b want=%b", ctrl_obs(), 10'b00000_01000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            excepttypeW = '0;
            total++;
            if ({pc_redirect, newpc} !== {1'b1, EXC_VEC}) begin
                bad++;
                $display("FAIL redir_hold%0d got=%b/%h want=1/%h", i, pc_redirect, newpc, EXC_VEC);
            end
        end
        ifetch_ready = 1'b1;
        tick();
        ifetch_ready = 1'b0;
        #1;
        total++;
        if ({pc_redirect, newpc} !== {1'b0, EXC_VEC}) begin
            bad++;
            $display("FAIL redir_done got=%b/%h want=0/%h", pc_redirect, newpc, EXC_VEC);
        end
    endtask

    task automatic test_eret();
        do_reset();
        excepttypeW = ERET; cp0_epcW = 32'h8000_1234;
        tick();
        clear_inputs();
        #1;
        total++;
        if ({pc_redirect, newpc} !== {1'b1, 32'h8000_1234}) begin
            bad++;
            $display("FAIL eret_pc got=%b/%h want=1/80001234", pc_redirect, newpc);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({pc_redirect, newpc, ctrl_obs()} !== 43'b0) begin
            bad++;
            $display("FAIL reset_in_redir got=%b/%h/%b want=0/0/0", pc_redirect, newpc, ctrl_obs());
        end
        tick();
        resetn = 1'b1;
        tick();
        total++;
        if (pc_redirect !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_redir got=%b want=0", pc_redirect);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        repeat (14) tick();
        total++;
        if (stall_cycles !== 4'd14) begin
            bad++;
            $display("FAIL cnt_14 got=%0d want=14", stall_cycles);
        end
        repeat (6) tick();
        total++;
        if (stall_cycles !== 4'd15) begin
            bad++;
            $display("FAIL cnt_sat got=%0d want=15", stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [60:0] exp_v;
        logic [60:0] obs_v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
            rdE = 5'($urandom_range(0, 7)); writeregE = 5'($urandom_range(0, 7));
            writeregM = 5'($urandom_range(0, 7)); writecp0M = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7)); writecp0W = 5'($urandom_range(0, 7));
            branchD = ($urandom_range(0, 3) == 0); jrD = ($urandom_range(0, 3) == 0);
            balD = ($urandom_range(0, 3) == 0); regwriteE = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 2) == 0); mdu_busyE = ($urandom_range(0, 5) == 0);
            regwriteM = 1'($urandom_range(0, 1)); memtoregM = ($urandom_range(0, 2) == 0);
            hilowriteM = ($urandom_range(0, 3) == 0); cp0writeM = 1'($urandom_range(0, 1));
            dstallM = ($urandom_range(0, 5) == 0); regwriteW = 1'($urandom_range(0, 1));
            hilowriteW = ($urandom_range(0, 3) == 0); cp0writeW = 1'($urandom_range(0, 1));
            ifetch_ready = 1'($urandom_range(0, 1));
            cp0_epcW = $urandom;
            if ($urandom_range(0, 11) == 0)
                excepttypeW = ($urandom_range(0, 1) == 1) ? ERET : 32'($urandom_range(1, 31));
            else
                excepttypeW = '0;
            #1;
            exp_v = all_ref();
            obs_v = all_obs();
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL random_cycle%0d got=%h want=%h", n, obs_v, exp_v);
            end
            @(posedge clk);
            if (exp_v[60] && m_cnt < CMAX) m_cnt++;
            if (!m_redir && excepttypeW != 0) begin
                m_newpc = (excepttypeW == ERET) ? cp0_epcW : EXC_VEC;
                m_redir = 1'b1;
            end else if (m_redir && ifetch_ready) begin
                m_redir = 1'b0;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_bal();
        test_forward();
        test_exception();
        test_eret();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
